// File: rtl/delay_injector_pkg.sv
// Shared types and constants for the multi-channel delay injector.
// LFSR constants are consumed only when DELAY_JITTER_EN is defined.
package delay_injector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    HOLD,
    CHECK_REPEAT
  } chan_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11 -> bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clamp_delay(input int value, input int max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/delay_channel.sv
// One delay channel: accept, count down, hold until done, then
// optionally accept a back-to-back request.
module delay_channel
  import delay_injector_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DELAY   = 16,
  parameter int JITTER_BITS = 2,
  parameter int CW          = $clog2(MAX_DELAY + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [CW-1:0]          delay_cfg,
  input  logic [JITTER_BITS-1:0] jitter,
  input  logic                   ack_in,
  input  logic                   done_in,
  output logic                   req_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   busy
);

  chan_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW:0]   sum;
  logic [CW-1:0] load;

  // One extra bit so cfg + jitter clamps instead of wrapping
  assign sum  = {1'b0, delay_cfg} + (CW+1)'(jitter);
  assign load = CW'(clamp_delay(int'(sum), MAX_DELAY));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req_out  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE, CHECK_REPEAT: begin
          req_out <= 1'b0;
          if (req_in) begin
            state    <= COUNTING;
            cnt      <= load;
            data_out <= data_in;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        COUNTING: begin
          if (cnt == '0) begin
            req_out <= 1'b1;
            state   <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (ack_in || done_in)
            req_out <= 1'b0;
          if (done_in)
            state <= CHECK_REPEAT;
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_delay_injector.sv
// Programmable per-channel latency injector for slow-memory emulation.
// Define DELAY_JITTER_EN to add LFSR jitter to each accepted delay.
module multi_channel_delay_injector
  import delay_injector_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_DELAY    = 16,
  parameter int JITTER_BITS  = 2,
  localparam int CW          = $clog2(MAX_DELAY + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHANNELS-1:0]          req_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CHANNELS*CW-1:0]       delay_cfg,
  input  logic [NUM_CHANNELS-1:0]          ack_in,
  input  logic [NUM_CHANNELS-1:0]          done_in,
  output logic [NUM_CHANNELS-1:0]          req_out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0]          busy
);

`ifdef DELAY_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [JITTER_BITS-1:0] jit;

`ifdef DELAY_JITTER_EN
    for (genvar b = 0; b < JITTER_BITS; b++) begin : g_jb
      assign jit[b] = lfsr[(i*JITTER_BITS + b) % 16];
    end
`else
    assign jit = '0;
`endif

    delay_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MAX_DELAY   (MAX_DELAY),
      .JITTER_BITS (JITTER_BITS),
      .CW          (CW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in[i]),
      .data_in   (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .delay_cfg (delay_cfg[i*CW +: CW]),
      .jitter    (jit),
      .ack_in    (ack_in[i]),
      .done_in   (done_in[i]),
      .req_out   (req_out[i]),
      .data_out  (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_delay_injector.sv
// Bench for multi_channel_delay_injector: deadline-based model,
// per-cycle compare, directed literal checks, random traffic.
module tb_multi_channel_delay_injector;

  localparam int NC   = 4;
  localparam int DW   = 32;
  localparam int MAXD = 16;
  localparam int CW   = 5;
  localparam int JB   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC-1:0]    req_in = '0;
  logic [NC-1:0]    ack_in = '0;
  logic [NC-1:0]    done_in = '0;
  logic [NC*DW-1:0] data_in = '0;
  logic [NC*CW-1:0] delay_cfg = '0;
  logic [NC-1:0]    req_out;
  logic [NC*DW-1:0] data_out;
  logic [NC-1:0]    busy;

  multi_channel_delay_injector #(
    .NUM_CHANNELS (NC),
    .DATA_WIDTH   (DW),
    .MAX_DELAY    (MAXD),
    .JITTER_BITS  (JB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .data_in   (data_in),
    .delay_cfg (delay_cfg),
    .ack_in    (ack_in),
    .done_in   (done_in),
    .req_out   (req_out),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit armed   = 0;

  // Model: 0 free, 1 waiting for deadline, 2 presenting, 3 just done
  int          m_mode [NC];
  int          m_dead [NC];
  bit          m_req  [NC];
  logic [DW-1:0] m_data [NC];
  int unsigned m_lfsr;
  int          lat [NC];

  always @(posedge clk) begin : model
    int d;
    int j;
    cyc++;
    if (!rst_n) begin
      armed  = 1;
      m_lfsr = 32'hACE1;
      for (int c = 0; c < NC; c++) begin
        m_mode[c] = 0;
        m_req[c]  = 0;
        m_data[c] = '0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        d = int'(delay_cfg[c*CW +: CW]);
        j = 0;
`ifdef DELAY_JITTER_EN
        for (int b = 0; b < JB; b++)
          j = j | (int'((m_lfsr >> ((c*JB + b) % 16)) & 1) << b);
`endif
        d = d + j;
        if (d > MAXD) d = MAXD;
        case (m_mode[c])
          0, 3: begin
            if (req_in[c]) begin
              m_mode[c] = 1;
              m_dead[c] = cyc + d + 1;
              m_data[c] = data_in[c*DW +: DW];
            end else begin
              m_mode[c] = 0;
            end
          end
          1: if (cyc == m_dead[c]) begin
            m_req[c]  = 1;
            m_mode[c] = 2;
          end
          default: begin
            if (ack_in[c] || done_in[c]) m_req[c] = 0;
            if (done_in[c]) m_mode[c] = 3;
          end
        endcase
      end
`ifdef DELAY_JITTER_EN
      m_lfsr = ((m_lfsr >> 1) |
        ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^
           (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15)) & 32'hFFFF;
`endif
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int c = 0; c < NC; c++) begin
        vectors++;
        if (req_out[c] !== m_req[c] ||
            busy[c] !== (m_mode[c] != 0) ||
            data_out[c*DW +: DW] !== m_data[c]) begin
          errors++;
          $display("FAIL model cyc%0d ch%0d: req_out=%b busy=%b data=%h, required %b %b %h",
                   cyc, c, req_out[c], busy[c], data_out[c*DW +: DW],
                   m_req[c], (m_mode[c] != 0), m_data[c]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [NC-1:0] mask, input int cfg,
                        input logic [DW-1:0] d);
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        req_in[c] = 1'b1;
        delay_cfg[c*CW +: CW] = CW'(cfg);
        data_in[c*DW +: DW] = d;
      end
    end
    @(negedge clk);
    req_in = req_in & ~mask;
  endtask

  // Negedges after the accept edge until req_out rises (-1 if never)
  task automatic measure(input logic [NC-1:0] mask);
    for (int c = 0; c < NC; c++) lat[c] = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++)
        if (mask[c] && lat[c] < 0 && req_out[c]) lat[c] = k;
    end
  endtask

  task automatic pulse_done(input logic [NC-1:0] mask,
                            input logic [NC-1:0] amask);
    @(negedge clk);
    done_in = mask;
    ack_in  = amask;
    @(negedge clk);
    done_in = '0;
    ack_in  = '0;
  endtask

  initial begin
    bit stale;
    repeat (2) @(negedge clk);
    check("reset req_out", 64'(req_out), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset data_out", 64'(data_out[63:0]), 64'h0);
    rst_n = 1'b1;

    launch(4'b0001, 3, 32'hDEADBEEF);
    check("ch0 busy next edge", 64'(busy), 64'h1);
    measure(4'b0001);
    check("ch0 latency cfg3", 64'(lat[0]), 64'd4);
    check("ch0 data", 64'(data_out[31:0]), 64'hDEADBEEF);
    check("others idle", 64'(req_out[3:1]), 64'h0);

    pulse_done(4'b0000, 4'b0001);
    check("ack drops req", 64'(req_out[0]), 64'h0);
    check("ack keeps busy", 64'(busy[0]), 64'h1);

    pulse_done(4'b0001, 4'b0000);
    launch(4'b0001, 2, 32'hCAFEF00D);
    measure(4'b0001);
    check("back-to-back latency", 64'(lat[0]), 64'd3);
    check("back-to-back data", 64'(data_out[31:0]), 64'hCAFEF00D);

    pulse_done(4'b0001, 4'b0001);
    check("ack+done req", 64'(req_out[0]), 64'h0);
    check("ack+done busy", 64'(busy[0]), 64'h1);
    @(negedge clk);
    check("ack+done idle", 64'(busy[0]), 64'h0);

    launch(4'b0001, 0, 32'h12345678);
    measure(4'b0001);
    check("cfg0 latency", 64'(lat[0]), 64'd1);
    pulse_done(4'b0001, 4'b0000);
    @(negedge clk);

    launch(4'b0010, 31, 32'h0BADF00D);
    measure(4'b0010);
    check("clamp latency", 64'(lat[1]), 64'd17);
    pulse_done(4'b0010, 4'b0000);
    @(negedge clk);

    launch(4'b0100, 0, 32'h22222222);
    @(negedge clk);
    check("ch2 in hold", 64'(req_out[2]), 64'h1);
    launch(4'b0010, 8, 32'h11111111);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset req_out", 64'(req_out), 64'h0);
    check("mid reset busy", 64'(busy), 64'h0);
    check("mid reset data", 64'(data_out), 64'h0);
    rst_n = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_out != '0) stale = 1;
    end
    check("no stale req_out", 64'(stale), 64'h0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    launch(4'b1111, 4, 32'h5A5A5A5A);
    measure(4'b1111);
    for (int c = 0; c < NC; c++) begin
`ifdef DELAY_JITTER_EN
      check($sformatf("jitter range ch%0d", c),
            64'(lat[c] >= 5 && lat[c] <= 8), 64'h1);
`else
      check($sformatf("fixed latency ch%0d", c), 64'(lat[c]), 64'd5);
`endif
    end
    pulse_done(4'b1111, 4'b0000);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 199) != 0);
      req_in  = NC'($urandom & $urandom);
      ack_in  = NC'($urandom & $urandom);
      done_in = NC'($urandom & $urandom & $urandom);
      delay_cfg = (NC*CW)'($urandom);
      for (int c = 0; c < NC; c++)
        data_in[c*DW +: DW] = $urandom;
    end
    @(negedge clk);
    req_in = '0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
